// File: rtl/mem_ctrl_fsm.sv
// mem_ctrl_fsm: addressed read/write sequencer for a DEPTH x WIDTH register array.
// A request accepted in IDLE passes through SETUP and ACCESS_CYCLES of ACCESS.
// It ends with a one-cycle DONE in which valid (and err, for bad addresses) is high.
// Out-of-range requests skip straight to DONE and never touch the array.
module mem_ctrl_fsm #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 6,
  parameter int ADDR_W        = 3,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              rw,
  output logic [DEPTH-1:0]  word_en,
  output logic              valid,
  output logic              err,
  output logic [WIDTH-1:0]  rdata
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  rdata_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_word;
  logic              in_range;

  assign in_range = ({1'b0, addr} < DEPTH_L);

  // Read mux over the array, addressed by the captured address.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (addr_q == ADDR_W'(i)) rd_word = mem[i];
    end
  end

  // State sequencing, request capture, access counter, array and read register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (select) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (in_range) begin
              err_q <= 1'b0;
              state <= SETUP;
            end else begin
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        SETUP: begin
          cnt   <= CNT_W'(ACCESS_CYCLES - 1);
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DONE;
            if (op_q) begin
              for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr_q == ADDR_W'(i)) mem[i] <= wdata_q;
              end
            end else begin
              rdata_q <= rd_word;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Word-enable decode, active only while the access is in flight.
  always_comb begin
    word_en = '0;
    if (state == SETUP || state == ACCESS) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr_q == ADDR_W'(i)) word_en[i] = 1'b1;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign rw    = busy & op_q;
  assign valid = (state == DONE);
  assign err   = valid & err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Testbench for mem_ctrl_fsm: table of single transactions plus hand sequences
// for reset, ignored inputs, mid-access reset and back-to-back timing.
module tb_mem_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic       sel, op;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       busy, rw, valid, err;
  logic [5:0] word_en;
  logic [7:0] rdata;

  logic        sel_a, op_a, sel_b, op_b;
  logic [2:0]  addr2;
  logic [15:0] wdata2;
  logic        busy_a, rw_a, valid_a, err_a;
  logic        busy_b, rw_b, valid_b, err_b;
  logic [5:0]  word_en_a, word_en_b;
  logic [15:0] rdata_a, rdata_b;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  mem_ctrl_fsm u_dut (
    .clk(clk), .reset(reset), .select(sel), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .rw(rw), .word_en(word_en), .valid(valid), .err(err), .rdata(rdata)
  );

  mem_ctrl_fsm #(.WIDTH(16), .ACCESS_CYCLES(1)) u_ac1 (
    .clk(clk), .reset(reset), .select(sel_a), .op(op_a), .addr(addr2), .wdata(wdata2),
    .busy(busy_a), .rw(rw_a), .word_en(word_en_a), .valid(valid_a), .err(err_a),
    .rdata(rdata_a)
  );

  mem_ctrl_fsm #(.WIDTH(16), .ACCESS_CYCLES(4)) u_ac4 (
    .clk(clk), .reset(reset), .select(sel_b), .op(op_b), .addr(addr2), .wdata(wdata2),
    .busy(busy_b), .rw(rw_b), .word_en(word_en_b), .valid(valid_b), .err(err_b),
    .rdata(rdata_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       o;
    logic [2:0] a;
    logic [7:0] d;
    logic       e_err;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic vof(input int id);
    if (id == 0) return valid;
    else if (id == 1) return valid_a;
    else return valid_b;
  endfunction

  // Poll for a valid pulse on the chosen instance, bounded.
  task automatic wait_valid(input int id, input string nm, output int t);
    int k;
    k = 0;
    while (!vof(id) && k < 40) begin
      tick();
      k++;
    end
    check({nm, "_valid"}, 32'(vof(id)), 32'd1);
    t = cyc;
  endtask

  // One complete transaction on the default instance with timing and output checks.
  task automatic txn(input logic o, input logic [2:0] a, input logic [7:0] d,
                     input logic e_err, input logic [7:0] e_rd, input string nm);
    int k;
    logic [5:0] exp_we;
    exp_we = e_err ? 6'd0 : (6'd1 << a);
    sel = 1'b1; op = o; addr = a; wdata = d;
    tick();
    sel = 1'b0; op = ~o; addr = ~a; wdata = ~d;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    check({nm, "_word_en"}, 32'(word_en), 32'(exp_we));
    check({nm, "_rw"}, 32'(rw), 32'(o));
    k = 0;
    while (!valid && k < 20) begin
      tick();
      k++;
    end
    check({nm, "_latency"}, 32'(k), e_err ? 32'd0 : 32'd3);
    check({nm, "_valid"}, 32'(valid), 32'd1);
    check({nm, "_err"}, 32'(err), 32'(e_err));
    check({nm, "_rdata"}, 32'(rdata), 32'(e_rd));
    tick();
    check({nm, "_pulse_end"}, {30'd0, valid, busy}, 32'd0);
  endtask

  initial begin
    int t1, t2, t3, nv;

    tbl[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 3'd3, 8'h00, 1'b0, 8'hA5};
    tbl[2]  = '{1'b1, 3'd6, 8'hFF, 1'b1, 8'hA5};
    tbl[3]  = '{1'b1, 3'd7, 8'h11, 1'b1, 8'hA5};
    tbl[4]  = '{1'b0, 3'd6, 8'h00, 1'b1, 8'hA5};
    tbl[5]  = '{1'b1, 3'd5, 8'h5A, 1'b0, 8'hA5};
    tbl[6]  = '{1'b0, 3'd5, 8'h00, 1'b0, 8'h5A};
    tbl[7]  = '{1'b0, 3'd3, 8'h00, 1'b0, 8'hA5};
    tbl[8]  = '{1'b1, 3'd0, 8'hC3, 1'b0, 8'hA5};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hC3};
    tbl[10] = '{1'b0, 3'd4, 8'h00, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 3'd7, 8'h00, 1'b1, 8'h00};

    // Reset held for two edges with select high.
    reset = 1'b0; sel = 1'b1; op = 1'b1; addr = 3'd0; wdata = 8'hFF;
    sel_a = 1'b1; op_a = 1'b1; sel_b = 1'b1; op_b = 1'b1; addr2 = 3'd2; wdata2 = 16'hBEEF;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_word_en", 32'(word_en), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_sweep_busy", {30'd0, busy_a, busy_b}, 32'd0);
    reset = 1'b1; sel = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) txn(1'b0, 3'(i), 8'h00, 1'b0, 8'h00, "rst_read");

    for (int i = 0; i < 12; i++)
      txn(tbl[i].o, tbl[i].a, tbl[i].d, tbl[i].e_err, tbl[i].e_rd, $sformatf("vec%0d", i));

    // Inputs changed mid-transaction are ignored.
    sel = 1'b1; op = 1'b1; addr = 3'd1; wdata = 8'h3C;
    tick();
    op = 1'b0; addr = 3'd2; wdata = 8'h00;
    check("ign_word_en_setup", 32'(word_en), 32'h02);
    tick();
    check("ign_word_en_access", 32'(word_en), 32'h02);
    check("ign_rw", 32'(rw), 32'd1);
    wait_valid(0, "ign", t1);
    sel = 1'b0;
    tick();
    txn(1'b0, 3'd1, 8'h00, 1'b0, 8'h3C, "ign_rd1");
    txn(1'b0, 3'd2, 8'h00, 1'b0, 8'h00, "ign_rd2");

    // Reset during ACCESS of a write aborts it.
    sel = 1'b1; op = 1'b1; addr = 3'd4; wdata = 8'hAA;
    tick();
    sel = 1'b0;
    tick();
    check("mr_busy_access", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mr_outputs", {busy, valid, err, rw, word_en}, 32'd0);
    check("mr_rdata", 32'(rdata), 32'd0);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) nv++;
    end
    check("mr_no_valid", 32'(nv), 32'd0);
    txn(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, "mr_rd4");
    txn(1'b0, 3'd1, 8'h00, 1'b0, 8'h00, "mr_rd1");

    // Back-to-back on default instance: spacing 3+ACCESS_CYCLES = 5.
    sel = 1'b1; op = 1'b1; addr = 3'd2; wdata = 8'h77;
    wait_valid(0, "b2b_first", t1);
    tick();
    wait_valid(0, "b2b_second", t2);
    check("b2b_spacing", 32'(t2 - t1), 32'd5);
    sel = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) nv++;
    end
    check("b2b_no_queue", 32'(nv), 32'd0);
    txn(1'b0, 3'd2, 8'h00, 1'b0, 8'h77, "b2b_rd");

    // ACCESS_CYCLES = 1, WIDTH = 16.
    addr2 = 3'd2; wdata2 = 16'hBEEF;
    sel_a = 1'b1; op_a = 1'b1;
    wait_valid(1, "ac1_w1", t1);
    tick();
    wait_valid(1, "ac1_w2", t2);
    check("ac1_spacing", 32'(t2 - t1), 32'd4);
    op_a = 1'b0;
    tick();
    wait_valid(1, "ac1_rd", t3);
    check("ac1_rd_spacing", 32'(t3 - t2), 32'd4);
    check("ac1_rdata", 32'(rdata_a), 32'h0000BEEF);
    check("ac1_err", 32'(err_a), 32'd0);
    sel_a = 1'b0;
    tick();
    check("ac1_idle", 32'(busy_a), 32'd0);

    // ACCESS_CYCLES = 4, WIDTH = 16.
    sel_b = 1'b1; op_b = 1'b1;
    wait_valid(2, "ac4_w1", t1);
    tick();
    wait_valid(2, "ac4_w2", t2);
    check("ac4_spacing", 32'(t2 - t1), 32'd7);
    op_b = 1'b0;
    tick();
    wait_valid(2, "ac4_rd", t3);
    check("ac4_rd_spacing", 32'(t3 - t2), 32'd7);
    check("ac4_rdata", 32'(rdata_b), 32'h0000BEEF);
    check("ac4_err", 32'(err_b), 32'd0);
    sel_b = 1'b0;
    tick();
    check("ac4_idle", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_fsm.md
Name: mem_ctrl_fsm

Overview:
- Parametrised successor to the single-cell read/write FSM.
- Controls a DEPTH x WIDTH register-backed memory array held inside the block.
- Accepts one read or write request per transaction on a select/op interface, sequences it through setup and multi-cycle access phases, and reports completion with a one-cycle valid pulse.
- Adds addressing, configurable access latency, a busy indicator and out-of-range error reporting.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 6: number of words in the array. Must be >= 1 and <= 2**ADDR_W.
- ADDR_W, 3: address width in bits. Addresses >= DEPTH are out of range.
- ACCESS_CYCLES, 2: cycles spent in ACCESS state. Must be >= 1.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset: 0 at a rising clk edge resets the block.
- select  in  1  request strobe; sampled only in IDLE.
- op  in  1  request type: 1 = write, 0 = read. Sampled with select.
- addr  in  ADDR_W  word address, sampled with select.
- wdata  in  WIDTH  write data, sampled with select.
- busy  out  1  high in SETUP, ACCESS and DONE.
- rw  out  1  captured op while busy; 0 in IDLE.
- word_en  out  DEPTH  one-hot select of the addressed word during SETUP/ACCESS; otherwise 0.
- valid  out  1  one-cycle completion pulse, high only in DONE.
- err  out  1  high with valid when the request address was out of range.
- rdata  out  WIDTH  read result; holds its value until the next completed in-range read or reset.

Behaviour:
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Reset:
  - When reset == 0 at a rising edge: state becomes IDLE.
  - busy, rw, word_en, valid, err and rdata go to 0.
  - All array words clear to 0. The access counter clears to 0.
  - Reset has priority over every other event, including mid-transaction. An aborted write never modifies the array.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On an edge with select = 1, capture op, addr and wdata.
  - If addr < DEPTH, go to SETUP.
  - Otherwise go directly to DONE with the error flag set. There is no SETUP/ACCESS phase, word_en stays 0 and the array is untouched.
  - select = 0 keeps the block in IDLE.
- SETUP:
  - Lasts exactly 1 cycle. rw and word_en are driven.
  - The counter loads ACCESS_CYCLES-1, then the block moves to ACCESS.
- ACCESS:
  - Stays while the counter is non-zero, decrementing once per cycle.
  - On the edge where the counter is 0, the block moves to DONE.
    - Write: array[addr] <= captured wdata.
    - Read: rdata <= array[addr].
  - ACCESS therefore lasts exactly ACCESS_CYCLES cycles.
- DONE:
  - valid = 1 and err = error flag for exactly 1 cycle, then the block returns to IDLE unconditionally.
- Latency (in-range):
  - The accepting edge is E0.
  - valid is high in the cycle after edge E0+1+ACCESS_CYCLES.
  - The next request can be accepted at edge E0+3+ACCESS_CYCLES.
- Latency (out-of-range): valid/err are high in the cycle after E0.
- Boundary conditions:
  - select, op, addr and wdata are ignored outside IDLE. Changes mid-transaction have no effect, and select held high does not queue a request.
  - If select is still 1 in the first IDLE cycle after DONE, a new transaction starts (back-to-back).
  - addr = DEPTH-1 is valid. addr = DEPTH up to 2**ADDR_W-1 produces err.
  - An out-of-range read leaves rdata unchanged.
  - A write followed by a read of the same address returns the written data. There is no bypass requirement because transactions never overlap.

Test Plan:
- Reset: hold reset = 0 for 2 edges with select = 1 -> busy/valid/err/rw/word_en/rdata all 0; state IDLE; reading addr 0..5 afterwards returns 0x00.
- Write then read (defaults): write addr 3, wdata 0xA5 -> busy for 4 cycles; word_en = 6'b001000 and rw = 1 in SETUP/ACCESS; valid pulses 1 cycle, 3 edges after acceptance. Then read addr 3 -> valid with rdata = 0xA5, rw = 0, err = 0.
- Out of range: write addr 6, wdata 0xFF -> valid = 1, err = 1 in the cycle after acceptance; word_en stays 0. Subsequent reads of addr 0..5 return unchanged data; rdata is unchanged by the errored request.
- Input changes ignored: during an active write to addr 1 (0x3C), toggle op, addr = 2 and wdata = 0x00 -> only addr 1 is written with 0x3C; addr 2 is unchanged.
- Mid-operation reset: assert reset = 0 during ACCESS of a write to addr 4 -> next cycle IDLE with all outputs 0; addr 4 reads 0x00; no valid pulse.
- Back-to-back / parameter sweep: with select held at 1, exactly one transaction per 4+ACCESS_CYCLES-1 cycles. Repeat with ACCESS_CYCLES = 1 and 4 and WIDTH = 16 -> valid spacing of 4 and 7 cycles respectively; 0xBEEF round-trips intact.
